// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped tagged table of 2-bit saturating counters.
// Combinational guess lookup; check port trains one entry per rising edge.
module branch_predictor #(
    parameter int PC_WIDTH = 32,
    parameter int LINES = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PC_WIDTH-1:0] pc_guess,
    input  logic                is_br_guess,
    input  logic [PC_WIDTH-1:0] pc_check,
    input  logic                is_br_check,
    input  logic                br_taken_check,
    output logic                br_pred_taken
);
    localparam int IB = $clog2(LINES);
    localparam int TW = PC_WIDTH - IB;

    logic [LINES-1:0] valid;
    logic [TW-1:0]    tags [LINES];
    logic [1:0]       cnt  [LINES];

    logic [IB-1:0] idx_g, idx_c;
    logic [TW-1:0] tag_g, tag_c;
    logic          hit_g, hit_c;
    logic [1:0]    cnt_c, cnt_next;

    assign idx_g = pc_guess[IB-1:0];
    assign tag_g = pc_guess[PC_WIDTH-1:IB];
    assign idx_c = pc_check[IB-1:0];
    assign tag_c = pc_check[PC_WIDTH-1:IB];

    assign hit_g = valid[idx_g] && tags[idx_g] == tag_g;
    assign hit_c = valid[idx_c] && tags[idx_c] == tag_c;
    assign cnt_c = cnt[idx_c];

    // Gating with reset keeps the prediction low for the whole reset pulse.
    assign br_pred_taken = !reset && is_br_guess && hit_g && cnt[idx_g][1];

    always_comb begin
        cnt_next = br_taken_check ? 2'b10 : 2'b01;
        if (hit_c)
            cnt_next = br_taken_check ? (cnt_c == 2'b11 ? 2'b11 : cnt_c + 2'd1)
                                      : (cnt_c == 2'b00 ? 2'b00 : cnt_c - 2'd1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            valid <= '0;
        else if (is_br_check)
            valid[idx_c] <= 1'b1;
    end

    // Tags and counters are meaningless while invalid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (!reset && is_br_check) begin
            tags[idx_c] <= tag_c;
            cnt[idx_c]  <= cnt_next;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed plan plus random training against a per-line model.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_guess = '0;
    logic        is_br_guess = 1'b0;
    logic [31:0] pc_check = '0;
    logic        is_br_check = 1'b0;
    logic        br_taken_check = 1'b0;
    logic        br_pred_taken;

    int checks = 0;
    int errors = 0;

    // Model: each line remembers the full PC that owns it and a 0..3 strength.
    bit          m_valid [8];
    logic [31:0] m_pc    [8];
    int          m_cnt   [8];

    branch_predictor #(.PC_WIDTH(32), .LINES(8)) dut (
        .clk(clk),
        .reset(reset),
        .pc_guess(pc_guess),
        .is_br_guess(is_br_guess),
        .pc_check(pc_check),
        .is_br_check(is_br_check),
        .br_taken_check(br_taken_check),
        .br_pred_taken(br_pred_taken)
    );

    always #5 clk = ~clk;

    function automatic logic m_pred(input logic [31:0] pc, input logic gb);
        int i = int'(pc % 8);
        return !reset && gb && m_valid[i] && m_pc[i] == pc && m_cnt[i] >= 2;
    endfunction

    function automatic void m_train(input logic [31:0] pc, input logic br, input logic tk);
        int i = int'(pc % 8);
        if (!br) return;
        if (m_valid[i] && m_pc[i] == pc)
            m_cnt[i] = tk ? (m_cnt[i] == 3 ? 3 : m_cnt[i] + 1) : (m_cnt[i] == 0 ? 0 : m_cnt[i] - 1);
        else begin
            m_valid[i] = 1'b1;
            m_pc[i] = pc;
            m_cnt[i] = tk ? 2 : 1;
        end
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    endfunction

    task automatic chk(input string t, input logic [31:0] pc, input logic gb);
        logic exp;
        pc_guess = pc;
        is_br_guess = gb;
        #1;
        exp = m_pred(pc, gb);
        checks++;
        assert (br_pred_taken === exp) else begin
            errors++;
            $error("FAIL %s pc=%h got %b expected %b", t, pc, br_pred_taken, exp);
        end
    endtask

    task automatic train(input logic [31:0] pc, input logic br, input logic tk);
        @(negedge clk);
        pc_check = pc;
        is_br_check = br;
        br_taken_check = tk;
        @(posedge clk);
        m_train(pc, br, tk);
        #1;
        is_br_check = 1'b0;
    endtask

    initial begin
        m_clear();
        chk("in_reset", 32'h5, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        chk("reset_miss", 32'h5, 1'b1);
        train(32'h5, 1'b0, 1'b1);
        chk("no_train_en", 32'h5, 1'b1);

        train(32'h5, 1'b1, 1'b1); chk("alloc_10", 32'h5, 1'b1);
        train(32'h5, 1'b1, 1'b1); chk("inc_11", 32'h5, 1'b1);
        train(32'h5, 1'b1, 1'b1); chk("sat_11", 32'h5, 1'b1);
        train(32'h5, 1'b1, 1'b0); chk("dec_10", 32'h5, 1'b1);
        train(32'h5, 1'b1, 1'b0); chk("dec_01", 32'h5, 1'b1);
        train(32'h5, 1'b1, 1'b0); chk("dec_00", 32'h5, 1'b1);
        train(32'h5, 1'b1, 1'b0); chk("sat_00", 32'h5, 1'b1);
        train(32'h5, 1'b1, 1'b1); chk("inc_01", 32'h5, 1'b1);
        train(32'h5, 1'b1, 1'b1); chk("inc_10", 32'h5, 1'b1);
        train(32'h5, 1'b0, 1'b0); chk("hold_10", 32'h5, 1'b1);
        train(32'h5, 1'b1, 1'b1);
        chk("not_branch", 32'h5, 1'b0);

        for (int i = 0; i < 8; i++) begin
            train(32'(i), 1'b1, 1'b1);
            chk("alias_own", 32'(i), 1'b1);
            train(32'(i + 8), 1'b1, 1'b1);
            chk("alias_new", 32'(i + 8), 1'b1);
            chk("alias_evict", 32'(i), 1'b1);
        end

        train(32'h2, 1'b1, 1'b0);
        train(32'h2, 1'b1, 1'b0);
        train(32'h2, 1'b1, 1'b1);
        @(negedge clk);
        pc_check = 32'h2;
        is_br_check = 1'b1;
        br_taken_check = 1'b1;
        chk("same_cyc_pre", 32'h2, 1'b1);
        @(posedge clk);
        m_train(32'h2, 1'b1, 1'b1);
        #1;
        is_br_check = 1'b0;
        chk("same_cyc_post", 32'h2, 1'b1);

        train(32'h13, 1'b1, 1'b1);
        train(32'h14, 1'b1, 1'b1);
        chk("pre_reset", 32'h13, 1'b1);
        @(negedge clk);
        #1;
        reset = 1'b1;
        m_clear();
        chk("async_rst_a", 32'h13, 1'b1);
        chk("async_rst_b", 32'h14, 1'b1);
        chk("async_rst_c", 32'h2, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        chk("post_rst_miss", 32'h14, 1'b1);
        train(32'h2, 1'b1, 1'b1);
        chk("post_rst_alloc", 32'h2, 1'b1);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] pc;
            pc = {$urandom_range(0, 2) == 0 ? 32'hABCD_0000 : 32'h0, 24'h0, 3'($urandom_range(0, 1)), 3'($urandom)};
            train(pc, $urandom_range(0, 4) != 0, 1'($urandom));
            chk("rand_trained", pc, 1'($urandom_range(0, 5) != 0));
            pc[3:0] = 4'($urandom);
            chk("rand_other", pc, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
